// File: rtl/data_memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : data_memory_arbiter
// Description : Two-requester round-robin arbiter and 4-cycle access sequencer
//               for the 1024x18 data memory; one access in flight at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module data_memory_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 18
) (
    input  logic              clock,
    input  logic              reset_n,

    input  logic              req0_valid,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_address,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    output logic              resp0_valid,
    output logic [DATA_W-1:0] resp0_rdata,

    input  logic              req1_valid,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_address,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              resp1_valid,
    output logic [DATA_W-1:0] resp1_rdata,

    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_input,
    output logic              mem_str,
    input  logic [DATA_W-1:0] mem_data_output,

    output logic              grant_id,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_READ  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state_q;
    logic              last_grant_q;
    logic              grant_q;
    logic              wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata1_q;
    logic              resp0_valid_q;
    logic              resp1_valid_q;

    logic              grant_d;
    logic              accept;

    // On a tie the requester that did not win last time gets the slot.
    assign grant_d    = (req0_valid & req1_valid) ? ~last_grant_q : req1_valid;
    assign req0_ready = (state_q == S_IDLE) & req0_valid & ~grant_d;
    assign req1_ready = (state_q == S_IDLE) & req1_valid &  grant_d;
    assign accept     = req0_ready | req1_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            last_grant_q  <= 1'b1;
            grant_q       <= 1'b0;
            wr_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            rdata0_q      <= '0;
            rdata1_q      <= '0;
            resp0_valid_q <= 1'b0;
            resp1_valid_q <= 1'b0;
        end else begin
            resp0_valid_q <= (state_q == S_READ) & ~grant_q;
            resp1_valid_q <= (state_q == S_READ) &  grant_q;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        wr_q         <= grant_d ? req1_write   : req0_write;
                        addr_q       <= grant_d ? req1_address : req0_address;
                        wdata_q      <= grant_d ? req1_wdata   : req0_wdata;
                        grant_q      <= grant_d;
                        last_grant_q <= grant_d;
                        state_q      <= S_ISSUE;
                    end
                end
                S_ISSUE: state_q <= S_READ;
                S_READ: begin
                    // Writes return zero so the completion data is never stale.
                    if (grant_q) rdata1_q <= wr_q ? '0 : mem_data_output;
                    else         rdata0_q <= wr_q ? '0 : mem_data_output;
                    state_q <= S_DONE;
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign mem_str        = (state_q == S_ISSUE) & wr_q;
    assign mem_address    = addr_q;
    assign mem_data_input = ((state_q == S_ISSUE) || (state_q == S_READ)) ? wdata_q : '0;
    assign resp0_valid    = resp0_valid_q;
    assign resp1_valid    = resp1_valid_q;
    assign resp0_rdata    = rdata0_q;
    assign resp1_rdata    = rdata1_q;
    assign grant_id       = grant_q;
    assign busy           = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_data_memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_memory_arbiter
// Description : Scoreboard bench for data_memory_arbiter with a 1024x18 memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_memory_arbiter;

    localparam int AW = 10;
    localparam int DW = 18;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          req0_valid, req0_write, req0_ready, resp0_valid;
    logic [AW-1:0] req0_address;
    logic [DW-1:0] req0_wdata, resp0_rdata;
    logic          req1_valid, req1_write, req1_ready, resp1_valid;
    logic [AW-1:0] req1_address;
    logic [DW-1:0] req1_wdata, resp1_rdata;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_data_input, mem_data_output;
    logic          mem_str, grant_id, busy;

    always #5 clock = ~clock;

    data_memory_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clock(clock), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_write(req0_write), .req0_address(req0_address),
        .req0_wdata(req0_wdata), .req0_ready(req0_ready), .resp0_valid(resp0_valid),
        .resp0_rdata(resp0_rdata),
        .req1_valid(req1_valid), .req1_write(req1_write), .req1_address(req1_address),
        .req1_wdata(req1_wdata), .req1_ready(req1_ready), .resp1_valid(resp1_valid),
        .resp1_rdata(resp1_rdata),
        .mem_address(mem_address), .mem_data_input(mem_data_input), .mem_str(mem_str),
        .mem_data_output(mem_data_output), .grant_id(grant_id), .busy(busy)
    );

    // Memory model: word i powers up as 0x20000|i, writes land on the edge closing ISSUE.
    logic [DW-1:0] mem [0:1023];
    bit            mem_init;
    always @(posedge clock) begin
        if (!mem_init) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 18'h20000 | 18'(i);
            mem_init <= 1'b1;
        end else if (mem_str) begin
            mem[mem_address] <= mem_data_input;
        end
    end
    assign mem_data_output = mem[mem_address];

    logic [DW-1:0] exp0_q[$];
    logic [DW-1:0] exp1_q[$];
    bit            order_q[$];
    int            acc0_q[$];
    int            acc1_q[$];
    int            cyc;
    int            checks;
    int            failures;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_resp(input bit p);
        logic [DW-1:0] got;
        logic [DW-1:0] e;
        bit            o;
        int            a;
        got = p ? resp1_rdata : resp0_rdata;
        if ((p ? exp1_q.size() : exp0_q.size()) == 0) begin
            chk($sformatf("unexpected_resp%0d", p), 32'd1, 32'd0);
        end else begin
            e = p ? exp1_q.pop_front() : exp0_q.pop_front();
            chk($sformatf("resp%0d_rdata", p), 32'(got), 32'(e));
            chk($sformatf("resp%0d_grant_id", p), 32'(grant_id), 32'(p));
        end
        if (order_q.size() == 0) begin
            chk($sformatf("resp%0d_order_extra", p), 32'd1, 32'd0);
        end else begin
            o = order_q.pop_front();
            chk("grant_order", 32'(p), 32'(o));
        end
        if ((p ? acc1_q.size() : acc0_q.size()) != 0) begin
            a = p ? acc1_q.pop_front() : acc0_q.pop_front();
            chk($sformatf("resp%0d_latency", p), 32'(cyc - a), 32'd3);
        end
    endtask

    always @(negedge clock) begin
        if (!reset_n) begin
            acc0_q.delete();
            acc1_q.delete();
        end else begin
            if (req0_ready) acc0_q.push_back(cyc);
            if (req1_ready) acc1_q.push_back(cyc);
            if (resp0_valid) check_resp(1'b0);
            if (resp1_valid) check_resp(1'b1);
        end
    end

    task automatic drive(input bit p, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (p) begin
            req1_write = w; req1_address = a; req1_wdata = d; req1_valid = 1'b1;
        end else begin
            req0_write = w; req0_address = a; req0_wdata = d; req0_valid = 1'b1;
        end
    endtask

    task automatic wait_ready(input bit p);
        int n;
        bit got;
        n = 0;
        got = 1'b0;
        while (!got && n < 40) begin
            @(negedge clock);
            if (p ? req1_ready : req0_ready) got = 1'b1;
            else n++;
        end
        if (!got) chk($sformatf("req%0d_ready_timeout", p), 32'd0, 32'd1);
        @(posedge clock);
        #1;
        if (p) req1_valid = 1'b0;
        else   req0_valid = 1'b0;
    endtask

    task automatic req(input bit p, input bit w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [DW-1:0] exp);
        if (p) exp1_q.push_back(exp);
        else   exp0_q.push_back(exp);
        drive(p, w, a, d);
        wait_ready(p);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp0_q.size() != 0 || exp1_q.size() != 0 || busy) && n < 100) begin
            @(negedge clock);
            n++;
        end
        chk(name, 32'(exp0_q.size() + exp1_q.size()), 32'd0);
        @(posedge clock);
        #1;
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_req0_ready"},  32'(req0_ready),     32'd0);
        chk({tag, "_req1_ready"},  32'(req1_ready),     32'd0);
        chk({tag, "_resp0_valid"}, 32'(resp0_valid),    32'd0);
        chk({tag, "_resp1_valid"}, 32'(resp1_valid),    32'd0);
        chk({tag, "_resp0_rdata"}, 32'(resp0_rdata),    32'd0);
        chk({tag, "_resp1_rdata"}, 32'(resp1_rdata),    32'd0);
        chk({tag, "_mem_address"}, 32'(mem_address),    32'd0);
        chk({tag, "_mem_din"},     32'(mem_data_input), 32'd0);
        chk({tag, "_mem_str"},     32'(mem_str),        32'd0);
        chk({tag, "_grant_id"},    32'(grant_id),       32'd0);
        chk({tag, "_busy"},        32'(busy),           32'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        req0_valid = 1'b0; req0_write = 1'b0; req0_address = '0; req0_wdata = '0;
        req1_valid = 1'b0; req1_write = 1'b0; req1_address = '0; req1_wdata = '0;
        repeat (3) @(posedge clock);
        #1;
        reset_checks("por");
        @(negedge clock) reset_n = 1'b1;
        @(posedge clock);
        #1;

        // Test 1: reset lands mid-ISSUE of a write; the write must not reach memory.
        drive(1'b0, 1'b1, 10'h005, 18'h11111);
        wait_ready(1'b0);
        chk("t1_issue_mem_str",  32'(mem_str),        32'd1);
        chk("t1_issue_mem_addr", 32'(mem_address),    32'h005);
        chk("t1_issue_mem_din",  32'(mem_data_input), 32'h11111);
        #2 reset_n = 1'b0;
        #1 reset_checks("t1_rst");
        repeat (2) @(posedge clock);
        @(negedge clock) reset_n = 1'b1;
        @(posedge clock);
        #1;
        order_q.push_back(1'b0);
        req(1'b0, 1'b0, 10'h005, 18'h0, 18'h20005);
        drain("t1_drain");

        // Test 2: write then read back through requester 0.
        order_q.push_back(1'b0);
        order_q.push_back(1'b0);
        req(1'b0, 1'b1, 10'h000, 18'h2AAAA, 18'h00000);
        req(1'b0, 1'b0, 10'h000, 18'h00000, 18'h2AAAA);
        drain("t2_drain");

        // Test 3: tie straight after reset goes to requester 0 first.
        @(posedge clock);
        #1 reset_n = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock) reset_n = 1'b1;
        @(posedge clock);
        #1;
        reset_checks("t3_rst");
        order_q.push_back(1'b0);
        order_q.push_back(1'b1);
        fork
            req(1'b0, 1'b0, 10'h001, 18'h0, 18'h20001);
            req(1'b1, 1'b0, 10'h002, 18'h0, 18'h20002);
        join
        drain("t3_drain");

        // Test 4: sustained contention alternates grants.
        for (int i = 0; i < 4; i++) begin
            order_q.push_back(1'b0);
            order_q.push_back(1'b1);
        end
        fork
            begin
                for (int i = 0; i < 4; i++)
                    req(1'b0, 1'b0, 10'h100 + 10'(i), 18'h0, 18'h20100 + 18'(i));
            end
            begin
                for (int j = 0; j < 4; j++)
                    req(1'b1, 1'b0, 10'h200 + 10'(j), 18'h0, 18'h20200 + 18'(j));
            end
        join
        drain("t4_drain");

        // Test 5: write from requester 1 seen by a following read from requester 0.
        order_q.push_back(1'b1);
        order_q.push_back(1'b0);
        req(1'b1, 1'b1, 10'h3FF, 18'h33333, 18'h00000);
        req(1'b0, 1'b0, 10'h3FF, 18'h00000, 18'h33333);
        drain("t5_drain");

        // Test 6: requester 0 address changes while waiting; acceptance-edge value wins.
        order_q.push_back(1'b1);
        order_q.push_back(1'b0);
        exp0_q.push_back(18'h20020);
        fork
            req(1'b1, 1'b0, 10'h030, 18'h0, 18'h20030);
            begin
                @(posedge clock);
                #1 drive(1'b0, 1'b0, 10'h010, 18'h0);
                @(posedge clock);
                #1 req0_address = 10'h020;
                wait_ready(1'b0);
            end
        join
        drain("t6_drain");
        chk("order_queue_empty", 32'(order_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
